// File: rtl/multicycle_controller_pkg.sv
// rtl/multicycle_controller_pkg.sv - shared encodings for the multicycle RV32I controller
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic       ADR_PC        = 1'b0;
  localparam logic       ADR_ALUOUT    = 1'b1;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCA_PC       = 2'b00;
  localparam logic [1:0] SRCA_OLDPC    = 2'b01;
  localparam logic [1:0] SRCA_RS1      = 2'b10;
  localparam logic [1:0] SRCB_RS2      = 2'b00;
  localparam logic [1:0] SRCB_IMM      = 2'b01;
  localparam logic [1:0] SRCB_FOUR     = 2'b10;
  localparam logic [1:0] IMM_I         = 2'b00;
  localparam logic [1:0] IMM_S         = 2'b01;
  localparam logic [1:0] IMM_B         = 2'b10;
  localparam logic [1:0] IMM_J         = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction fields, flags and control outputs between IR, datapath and controller
interface multicycle_controller_if #(
  parameter int ALUCTRL_W = 3
);
  logic [6:0]           op;
  logic [2:0]           funct3;
  logic                 funct7b5;
  logic                 zero;
  logic                 lt;
  logic                 mem_ready;
  logic                 PCWrite;
  logic                 AdrSrc;
  logic                 MemWrite;
  logic                 IRWrite;
  logic                 RegWrite;
  logic [1:0]           ResultSrc;
  logic [1:0]           ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ImmSrc;
  logic [ALUCTRL_W-1:0] ALUControl;
  logic                 illegal;

  modport master (
    input  op, funct3, funct7b5, zero, lt, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal
  );

  modport slave (
    output op, funct3, funct7b5, zero, lt, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// rtl/multicycle_controller_alu_decoder.sv - ALUOp/funct -> ALUControl, carried over from the single-cycle core
module alu_decoder
  import multicycle_controller_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  aluop_t               aluop,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 op5,
  output logic [ALUCTRL_W-1:0] alu_control
);

  always_comb begin
    alu_control = '0;
    case (aluop)
      ALUOP_ADD: alu_control[2:0] = ALU_ADD;
      ALUOP_SUB: alu_control[2:0] = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type sub from addi, whose bit 30 is immediate data
          3'b000:  alu_control[2:0] = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control[2:0] = ALU_SLT;
          3'b110:  alu_control[2:0] = ALU_OR;
          3'b111:  alu_control[2:0] = ALU_AND;
          default: alu_control[2:0] = ALU_ADD;
        endcase
      end
      default: alu_control[2:0] = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I control FSM; define BRANCH_EXT_EN for bne/blt/bge
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int ALUCTRL_W       = 3,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_controller_if.master bus
);

  state_t               state;
  state_t               out_state;
  state_t               decode_next;
  state_t               illegal_next;
  aluop_t               aluop;
  logic                 taken;
  logic                 branch_ok;
  logic                 pc_update;
  logic                 branch;
  logic                 ir_write;
  logic                 mem_write;
  logic                 reg_write;
  logic                 trap;
  logic                 adr_src;
  logic [1:0]           result_src;
  logic [1:0]           src_a;
  logic [1:0]           src_b;
  logic [ALUCTRL_W-1:0] alu_control;

`ifdef BRANCH_EXT_EN
  always_comb begin
    taken     = 1'b0;
    branch_ok = 1'b1;
    case (bus.funct3)
      3'b000:  taken = bus.zero;
      3'b001:  taken = !bus.zero;
      3'b100:  taken = bus.lt;
      3'b101:  taken = !bus.lt;
      default: branch_ok = 1'b0;
    endcase
  end
`else
  logic unused_lt;
  assign unused_lt = bus.lt;
  assign taken     = bus.zero;
  assign branch_ok = 1'b1;
`endif

  // Unsupported branch conditions are rejected here so S_BEQ never acts on them
  always_comb begin
    if (TRAP_ON_ILLEGAL) illegal_next = S_TRAP;
    else                 illegal_next = S_FETCH;
    case (bus.op)
      OP_LOAD, OP_STORE: decode_next = S_MEMADR;
      OP_RTYPE:          decode_next = S_EXECR;
      OP_ITYPE:          decode_next = S_EXECI;
      OP_JAL:            decode_next = S_JAL;
      OP_BRANCH:         decode_next = branch_ok ? S_BEQ : illegal_next;
      default:           decode_next = illegal_next;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
        S_DECODE:   state <= decode_next;
        S_MEMADR:   state <= bus.op[5] ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (bus.mem_ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (bus.mem_ready) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_JAL:      state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BEQ:      state <= S_FETCH;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // During reset the outputs already look like S_FETCH, whatever state was interrupted
  always_comb begin
    out_state = state;
    if (reset) out_state = S_FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    trap       = 1'b0;
    adr_src    = ADR_PC;
    result_src = RES_ALUOUT;
    src_a      = SRCA_PC;
    src_b      = SRCB_RS2;
    aluop      = ALUOP_ADD;
    case (out_state)
      S_FETCH: begin
        src_b      = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = bus.mem_ready;
        pc_update  = bus.mem_ready;
      end
      S_DECODE: begin
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        src_a = SRCA_RS1;
        src_b = SRCB_IMM;
      end
      S_MEMREAD: adr_src = ADR_ALUOUT;
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = ADR_ALUOUT;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        src_a = SRCA_RS1;
        aluop = ALUOP_FUNCT;
      end
      S_EXECI: begin
        src_a = SRCA_RS1;
        src_b = SRCB_IMM;
        aluop = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        src_a     = SRCA_OLDPC;
        src_b     = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        src_a  = SRCA_RS1;
        aluop  = ALUOP_SUB;
        branch = 1'b1;
      end
      S_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

  alu_decoder #(
    .ALUCTRL_W (ALUCTRL_W)
  ) u_alu_decoder (
    .aluop       (aluop),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.op[5]),
    .alu_control (alu_control)
  );

  assign bus.PCWrite    = !reset && (pc_update || (branch && taken));
  assign bus.IRWrite    = !reset && ir_write;
  assign bus.MemWrite   = !reset && mem_write;
  assign bus.RegWrite   = !reset && reg_write;
  assign bus.illegal    = !reset && trap;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ImmSrc     = imm_src_of(bus.op);
  assign bus.ALUControl = alu_control;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller (trap and no-trap instances)
module tb_multicycle_controller;

  typedef enum int {
    T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
    T_EXECR, T_EXECI, T_ALUWB, T_JAL, T_BEQ, T_TRAP
  } tstate_t;

  typedef struct packed {
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       illegal;
  } outs_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       zero;
    int         len;
    tstate_t    seq[5];
    logic [2:0] alu_x;
    logic       pcw_b;
  } vec_t;

  logic  clk = 1'b0;
  logic  reset;
  int    n_tests;
  int    n_fail;
  outs_t sb[$];
  outs_t act1;
  outs_t act2;
  vec_t  vecs[12];

  multicycle_controller_if #(.ALUCTRL_W(3)) bus ();
  multicycle_controller_if #(.ALUCTRL_W(3)) bus2 ();

  multicycle_controller #(.ALUCTRL_W(3), .TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  multicycle_controller #(.ALUCTRL_W(3), .TRAP_ON_ILLEGAL(1'b0)) dut_notrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.master)
  );

  assign bus2.op        = bus.op;
  assign bus2.funct3    = bus.funct3;
  assign bus2.funct7b5  = bus.funct7b5;
  assign bus2.zero      = bus.zero;
  assign bus2.lt        = bus.lt;
  assign bus2.mem_ready = bus.mem_ready;

  assign act1 = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                 bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl, bus.illegal};
  assign act2 = {bus2.PCWrite, bus2.AdrSrc, bus2.MemWrite, bus2.IRWrite, bus2.RegWrite,
                 bus2.ResultSrc, bus2.ALUSrcA, bus2.ALUSrcB, bus2.ImmSrc, bus2.ALUControl, bus2.illegal};

  always #5 clk = ~clk;

  function automatic logic [1:0] imm_exp(input logic [6:0] opc);
    if (opc == 7'b0100011) return 2'b01;
    if (opc == 7'b1100011) return 2'b10;
    if (opc == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  function automatic outs_t exp_out(input tstate_t st, input logic rdy, input logic rst,
                                    input logic [6:0] opc, input logic [2:0] alu_x,
                                    input logic pcw_b);
    outs_t e = '0;
    e.ImmSrc = imm_exp(opc);
    if (rst) st = T_FETCH;
    case (st)
      T_FETCH:    begin e.ALUSrcB = 2'b10; e.ResultSrc = 2'b10; e.IRWrite = rdy; e.PCWrite = rdy; end
      T_DECODE:   begin e.ALUSrcA = 2'b01; e.ALUSrcB = 2'b01; end
      T_MEMADR:   begin e.ALUSrcA = 2'b10; e.ALUSrcB = 2'b01; end
      T_MEMREAD:  e.AdrSrc = 1'b1;
      T_MEMWB:    begin e.ResultSrc = 2'b01; e.RegWrite = 1'b1; end
      T_MEMWRITE: begin e.AdrSrc = 1'b1; e.MemWrite = 1'b1; end
      T_EXECR:    begin e.ALUSrcA = 2'b10; e.ALUControl = alu_x; end
      T_EXECI:    begin e.ALUSrcA = 2'b10; e.ALUSrcB = 2'b01; e.ALUControl = alu_x; end
      T_ALUWB:    e.RegWrite = 1'b1;
      T_JAL:      begin e.ALUSrcA = 2'b01; e.ALUSrcB = 2'b10; e.PCWrite = 1'b1; end
      T_BEQ:      begin e.ALUSrcA = 2'b10; e.ALUControl = 3'b001; e.PCWrite = pcw_b; end
      T_TRAP:     e.illegal = 1'b1;
      default:    ;
    endcase
    if (rst) begin
      e.IRWrite = 1'b0;
      e.PCWrite = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string nm, input outs_t a, input outs_t e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h", nm, a, e);
    end
  endtask

  // Called at posedge+1: drive, push expectation, sample at posedge+3, advance one cycle
  task automatic step(input string nm, input tstate_t st, input logic rdy, input logic rst_v,
                      input logic [2:0] alu_x, input logic pcw_b);
    outs_t e;
    bus.mem_ready = rdy;
    reset         = rst_v;
    sb.push_back(exp_out(st, rdy, rst_v, bus.op, alu_x, pcw_b));
    #2;
    e = sb.pop_front();
    check(nm, act1, e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required to have finished");
    $fatal(1);
  end

  initial begin
    logic bne_taken;
`ifdef BRANCH_EXT_EN
    bne_taken = 1'b1;
`else
    bne_taken = 1'b0;
`endif
    n_tests = 0;
    n_fail  = 0;
    vecs[0]  = '{"lw",   7'b0000011, 3'b010, 1'b0, 1'b0, 5, '{T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB}, 3'b000, 1'b0};
    vecs[1]  = '{"sw",   7'b0100011, 3'b010, 1'b0, 1'b0, 4, '{T_FETCH, T_DECODE, T_MEMADR, T_MEMWRITE, T_FETCH}, 3'b000, 1'b0};
    vecs[2]  = '{"sub",  7'b0110011, 3'b000, 1'b1, 1'b0, 4, '{T_FETCH, T_DECODE, T_EXECR, T_ALUWB, T_FETCH}, 3'b001, 1'b0};
    vecs[3]  = '{"add",  7'b0110011, 3'b000, 1'b0, 1'b0, 4, '{T_FETCH, T_DECODE, T_EXECR, T_ALUWB, T_FETCH}, 3'b000, 1'b0};
    vecs[4]  = '{"slt",  7'b0110011, 3'b010, 1'b0, 1'b0, 4, '{T_FETCH, T_DECODE, T_EXECR, T_ALUWB, T_FETCH}, 3'b101, 1'b0};
    vecs[5]  = '{"or",   7'b0110011, 3'b110, 1'b0, 1'b0, 4, '{T_FETCH, T_DECODE, T_EXECR, T_ALUWB, T_FETCH}, 3'b011, 1'b0};
    vecs[6]  = '{"and",  7'b0110011, 3'b111, 1'b0, 1'b0, 4, '{T_FETCH, T_DECODE, T_EXECR, T_ALUWB, T_FETCH}, 3'b010, 1'b0};
    vecs[7]  = '{"addi", 7'b0010011, 3'b000, 1'b1, 1'b0, 4, '{T_FETCH, T_DECODE, T_EXECI, T_ALUWB, T_FETCH}, 3'b000, 1'b0};
    vecs[8]  = '{"jal",  7'b1101111, 3'b000, 1'b0, 1'b0, 4, '{T_FETCH, T_DECODE, T_JAL, T_ALUWB, T_FETCH}, 3'b000, 1'b0};
    vecs[9]  = '{"beq_t",7'b1100011, 3'b000, 1'b0, 1'b1, 3, '{T_FETCH, T_DECODE, T_BEQ, T_FETCH, T_FETCH}, 3'b000, 1'b1};
    vecs[10] = '{"beq_n",7'b1100011, 3'b000, 1'b0, 1'b0, 3, '{T_FETCH, T_DECODE, T_BEQ, T_FETCH, T_FETCH}, 3'b000, 1'b0};
    vecs[11] = '{"bne",  7'b1100011, 3'b001, 1'b0, 1'b0, 3, '{T_FETCH, T_DECODE, T_BEQ, T_FETCH, T_FETCH}, 3'b000, bne_taken};

    reset         = 1'b1;
    bus.op        = 7'b0000011;
    bus.funct3    = 3'b010;
    bus.funct7b5  = 1'b0;
    bus.zero      = 1'b0;
    bus.lt        = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    step("reset_c1", T_FETCH, 1'b1, 1'b1, 3'b000, 1'b0);
    step("reset_c2", T_FETCH, 1'b1, 1'b1, 3'b000, 1'b0);

    foreach (vecs[i]) begin
      bus.op       = vecs[i].op;
      bus.funct3   = vecs[i].f3;
      bus.funct7b5 = vecs[i].f7;
      bus.zero     = vecs[i].zero;
      for (int k = 0; k < vecs[i].len; k++)
        step(vecs[i].name, vecs[i].seq[k], 1'b1, 1'b0, vecs[i].alu_x, vecs[i].pcw_b);
    end

    // store with a fetch stall and three wait cycles in S_MEMWRITE
    bus.op = 7'b0100011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    step("sw_fetch_wait", T_FETCH, 1'b0, 1'b0, 3'b000, 1'b0);
    step("sw_fetch", T_FETCH, 1'b1, 1'b0, 3'b000, 1'b0);
    step("sw_decode", T_DECODE, 1'b1, 1'b0, 3'b000, 1'b0);
    step("sw_memadr", T_MEMADR, 1'b1, 1'b0, 3'b000, 1'b0);
    for (int k = 0; k < 3; k++)
      step("sw_memwrite_wait", T_MEMWRITE, 1'b0, 1'b0, 3'b000, 1'b0);
    step("sw_memwrite_done", T_MEMWRITE, 1'b1, 1'b0, 3'b000, 1'b0);
    step("sw_back_fetch", T_FETCH, 1'b0, 1'b0, 3'b000, 1'b0);

    // load with one wait cycle in S_MEMREAD
    bus.op = 7'b0000011;
    step("lw_fetch", T_FETCH, 1'b1, 1'b0, 3'b000, 1'b0);
    step("lw_decode", T_DECODE, 1'b1, 1'b0, 3'b000, 1'b0);
    step("lw_memadr", T_MEMADR, 1'b1, 1'b0, 3'b000, 1'b0);
    step("lw_memread_wait", T_MEMREAD, 1'b0, 1'b0, 3'b000, 1'b0);
    step("lw_memread_done", T_MEMREAD, 1'b1, 1'b0, 3'b000, 1'b0);
    step("lw_memwb", T_MEMWB, 1'b1, 1'b0, 3'b000, 1'b0);

    // reset landing in S_MEMREAD must abort the load with no writeback
    step("abort_fetch", T_FETCH, 1'b1, 1'b0, 3'b000, 1'b0);
    step("abort_decode", T_DECODE, 1'b1, 1'b0, 3'b000, 1'b0);
    step("abort_memadr", T_MEMADR, 1'b1, 1'b0, 3'b000, 1'b0);
    step("abort_reset", T_MEMREAD, 1'b1, 1'b1, 3'b000, 1'b0);
    step("abort_after1", T_FETCH, 1'b0, 1'b0, 3'b000, 1'b0);
    step("abort_after2", T_FETCH, 1'b0, 1'b0, 3'b000, 1'b0);

    // illegal opcode: trapping instance parks, the other one skips it
    bus.op = 7'b1111111; bus.funct3 = 3'b000;
    for (int i = 0; i < 12; i++) begin
      outs_t e1;
      outs_t e2;
      tstate_t s1;
      tstate_t s2;
      bus.mem_ready = 1'b1;
      s1 = (i == 0) ? T_FETCH : ((i == 1) ? T_DECODE : T_TRAP);
      s2 = (i % 2 == 0) ? T_FETCH : T_DECODE;
      sb.push_back(exp_out(s1, 1'b1, 1'b0, bus.op, 3'b000, 1'b0));
      e2 = exp_out(s2, 1'b1, 1'b0, bus.op, 3'b000, 1'b0);
      #2;
      e1 = sb.pop_front();
      check("trap_seq", act1, e1);
      check("notrap_seq", act2, e2);
      @(posedge clk);
      #1;
    end
    step("trap_reset", T_FETCH, 1'b1, 1'b1, 3'b000, 1'b0);
    step("trap_exit", T_FETCH, 1'b0, 1'b0, 3'b000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle successor to the single-cycle ALUControl decoder. It is a Moore FSM that sequences each RV32I instruction across Fetch/Decode/Execute/Memory/Writeback over a shared memory port, with a ready handshake on memory. It generates the datapath mux selects, write enables and ALUControl from op/funct3/funct7b5/zero. It sits between the instruction register and the multicycle datapath.

Parameters:
ALUCTRL_W, 3, ALUControl width (>=3); bits above [2:0] driven 0.
TRAP_ON_ILLEGAL, 1, 1: an unknown opcode parks the FSM in S_TRAP; 0: it returns to S_FETCH (instruction skipped as a NOP).

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
op  input  7  opcode from the instruction register
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU zero flag
lt  input  1  ALU signed less-than flag; used only with BRANCH_EXT_EN
mem_ready  input  1  memory has completed the current access this cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
MemWrite  output  1  memory write strobe
IRWrite  output  1  instruction register enable
RegWrite  output  1  register file write enable
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1
ALUSrcB  output  2  00=rs2, 01=Imm, 10=const 4
ImmSrc  output  2  00=I, 01=S, 10=B, 11=J
ALUControl  output  ALUCTRL_W  000 add, 001 sub, 010 and, 011 or, 101 slt
illegal  output  1  high while in S_TRAP

Behaviour:
- State register only; outputs are a Moore function of state, except as noted below. ImmSrc decodes combinationally from op (lw/I-type 00, sw 01, beq 10, jal 11, others 00).
- Reset: state <= S_FETCH. While reset is high, PCWrite/IRWrite/MemWrite/RegWrite/illegal = 0. All other outputs take their S_FETCH values.
- Reset asserted mid-instruction aborts the instruction; there is no partial register or memory write after that edge.
- PCWrite = PCUpdate | (Branch & taken); taken = zero (beq).
- ALUOp: 00 -> add; 01 -> sub; 10 -> funct decode:
  - funct3 000: sub if op[5]&funct7b5, else add
  - 010: slt; 110: or; 111: and; others: add
- S_FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=PCUpdate=mem_ready. Hold until mem_ready, then -> S_DECODE.
- S_DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next state by op:
  - 0000011/0100011 -> S_MEMADR
  - 0110011 -> S_EXECR
  - 0010011 -> S_EXECI
  - 1101111 -> S_JAL
  - 1100011 -> S_BEQ
  - else -> S_TRAP, or S_FETCH when TRAP_ON_ILLEGAL=0
- S_MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. -> S_MEMREAD if op[5]=0, else S_MEMWRITE.
- S_MEMREAD: AdrSrc=1, ResultSrc=00. Hold until mem_ready -> S_MEMWB.
- S_MEMWB: ResultSrc=01, RegWrite=1 -> S_FETCH.
- S_MEMWRITE: AdrSrc=1, ResultSrc=00. MemWrite=1 held every cycle until mem_ready; mem_ready -> S_FETCH.
- S_EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> S_ALUWB.
- S_EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> S_ALUWB.
- S_ALUWB: ResultSrc=00, RegWrite=1 -> S_FETCH.
- S_JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> S_ALUWB (rd=PC+4).
- S_BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> S_FETCH.
- S_TRAP: illegal=1, all enables 0. Exit only by reset.
- Any output not listed for a state is 0.
- Latency with mem_ready tied 1, in cycles: lw 5, sw 4, R/I 4, jal 4, beq 3. Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.

Optional Feature:
BRANCH_EXT_EN.
- Defined: S_BEQ uses funct3 to pick the taken condition: 000 zero, 001 !zero, 100 lt, 101 !lt; other funct3 values -> illegal handling per TRAP_ON_ILLEGAL.
- Undefined: taken=zero for any funct3, and lt is ignored.

Decomposition:
- ctrl_pkg holds:
  - state enum (S_FETCH=0 … S_TRAP=11, 4 bits)
  - opcode constants
  - ALUOp and ALUControl encodings
  - mux-select encodings
- One sub-module, alu_decoder: combinational ALUOp/funct3/funct7b5/op[5] -> ALUControl. It is reused from the single-cycle design, widened to ALUCTRL_W.

Test Plan:
- reset=1 for 2 cycles, then lw (op=0000011), mem_ready=1 -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 only in cycle 5 with ResultSrc=01.
- sw with mem_ready low for 3 cycles in S_MEMWRITE -> MemWrite=1 for 4 consecutive cycles, AdrSrc=1, return to FETCH on the mem_ready edge.
- R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in S_EXECR; same op with funct7b5=0 -> 000; funct3=010 -> 101.
- beq with zero=1 -> PCWrite=1 in S_BEQ; with zero=0 -> PCWrite=0. With BRANCH_EXT_EN, funct3=001, zero=0 -> PCWrite=1.
- op=1111111 -> illegal=1 from cycle 3 and held for 10 cycles with no enables; TRAP_ON_ILLEGAL=0 -> back to FETCH, illegal stays 0.
- reset asserted during S_MEMREAD -> next cycle in S_FETCH, RegWrite never asserted.
